// File: rtl/ysyx_23060240_ifu_fetch.sv
// ysyx_23060240_ifu_fetch: PC owner and single-outstanding instruction fetcher feeding decode.
// Optional perf counters are enabled by defining IFU_PERF_CNT_EN.
module ysyx_23060240_ifu_fetch #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h80000000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, redir_pc;
    logic [31:0]       inst_q, inst_d;
    logic              kill_q, kill_d;
    assign redir_pc       = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign imem_req_valid = !rst && state_q == S_REQ && !redirect_valid;
    assign inst_valid     = !rst && state_q == S_HOLD;
    assign imem_req_addr  = pc_q;
    assign inst_pc        = pc_q;
    assign inst           = inst_q;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        kill_d  = kill_q;
        case (state_q)
            S_REQ: begin
                if (redirect_valid) pc_d = redir_pc;
                else if (imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    // A response that belongs to a squashed path is drained but never delivered
                    if (kill_q || redirect_valid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                        pc_d    = redirect_valid ? redir_pc : pc_q;
                    end else begin
                        inst_d  = imem_rsp_data;
                        state_d = S_HOLD;
                    end
                end else if (redirect_valid) begin
                    pc_d   = redir_pc;
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect_valid || inst_ready) begin
                    pc_d    = redirect_valid ? redir_pc : pc_q + ADDR_W'(4);
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            kill_q  <= kill_d;
        end
    end
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, stall_cnt_q, stall_cnt_d;
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + ((inst_valid && inst_ready) ? 32'd1 : 32'd0);
        stall_cnt_d = stall_cnt_q + ((state_q == S_WAIT && !imem_rsp_valid) ? 32'd1 : 32'd0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_stall_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_ysyx_23060240_ifu_fetch.sv
// tb_ysyx_23060240_ifu_fetch: directed stimulus with queue-based scoreboard for the fetch stage.
module tb_ysyx_23060240_ifu_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst, inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_req[$];
    logic [63:0] exp_inst[$];

    ysyx_23060240_ifu_fetch dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT completes a handshake
    always @(negedge clk) begin
        chk("excl_valids", {63'd0, imem_req_valid & inst_valid}, 64'd0);
        if (imem_req_valid && imem_req_ready) begin
            if (exp_req.size() == 0) chk("unexpected_req", {32'd0, imem_req_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("req_addr", {32'd0, imem_req_addr}, {32'd0, exp_req.pop_front()});
        end
        if (inst_valid && inst_ready) begin
            if (exp_inst.size() == 0) chk("unexpected_inst", {inst, inst_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
            else chk("inst_bundle", {inst, inst_pc}, exp_inst.pop_front());
        end
    end

    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int stall,
                         input int delay, input int hold, input logic redir, input logic [31:0] rpc);
        int n = 0;
        exp_req.push_back(addr);
        while (!imem_req_valid && n < 20) begin
            step();
            n++;
        end
        if (n == 20) chk("req_timeout", 64'd0, 64'd1);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", {63'd0, imem_req_valid}, 64'd1);
            chk("stall_addr", {32'd0, imem_req_addr}, {32'd0, addr});
            step();
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        for (int i = 1; i < delay; i++) begin
            @(negedge clk);
            chk("wait_no_inst", {63'd0, inst_valid}, 64'd0);
            step();
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, inst_valid}, 64'd1);
            chk("hold_bundle", {inst, inst_pc}, {data, addr});
            step();
        end
        exp_inst.push_back({data, addr});
        inst_ready     = 1'b1;
        redirect_valid = redir;
        redirect_pc    = rpc;
        step();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
    endtask

    initial begin
        imem_req_ready = 1'b1;
        step();
        @(negedge clk);
        chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        chk("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_addr", {32'd0, imem_req_addr}, 64'h8000_0000);
        step();
        imem_req_ready = 1'b0;
        rst = 1'b0;
        fetch(32'h8000_0000, 32'h0000_0413, 0, 1, 0, 1'b0, 32'h0);
        fetch(32'h8000_0004, 32'h0010_0093, 5, 3, 0, 1'b0, 32'h0);
`ifdef IFU_PERF_CNT_EN
        chk("perf_fetch", {32'd0, perf_fetch_cnt}, 64'd2);
        chk("perf_stall", {32'd0, perf_stall_cnt}, 64'd2);
`else
        chk("perf_fetch_off", {32'd0, perf_fetch_cnt}, 64'd0);
        chk("perf_stall_off", {32'd0, perf_stall_cnt}, 64'd0);
`endif
        // Squash while waiting: late response must be dropped
        exp_req.push_back(32'h8000_0008);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        step();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("kill_no_inst", {63'd0, inst_valid}, 64'd0);
        step();
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("kill_after_no_inst", {63'd0, inst_valid}, 64'd0);
        chk("kill_next_addr", {32'd0, imem_req_addr}, 64'h8000_0100);
        fetch(32'h8000_0100, 32'h0020_8113, 0, 1, 4, 1'b1, 32'h8000_0020);
        @(negedge clk);
        chk("redir_hold_addr", {32'd0, imem_req_addr}, 64'h8000_0020);
        // Redirect in S_REQ suppresses the request that cycle
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("redir_req_valid", {63'd0, imem_req_valid}, 64'd0);
        step();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        fetch(32'hFFFF_FFFC, 32'h1234_5678, 0, 2, 0, 1'b0, 32'h0);
        // Wrap to zero, then reset mid-fetch
        exp_req.push_back(32'h0000_0000);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_BABE;
        @(negedge clk);
        chk("post_rst_no_inst", {63'd0, inst_valid}, 64'd0);
        chk("post_rst_req_valid", {63'd0, imem_req_valid}, 64'd1);
        chk("post_rst_addr", {32'd0, imem_req_addr}, 64'h8000_0000);
        chk("post_rst_perf_fetch", {32'd0, perf_fetch_cnt}, 64'd0);
        chk("post_rst_perf_stall", {32'd0, perf_stall_cnt}, 64'd0);
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        @(negedge clk);
        chk("late_rsp_ignored", {63'd0, inst_valid}, 64'd0);
        fetch(32'h8000_0000, 32'h0000_0013, 0, 1, 0, 1'b0, 32'h0);
        repeat (3) step();
        chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
        chk("inst_queue_empty", 64'(exp_inst.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
